// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Issue controller placed directly in front of a pipelined divider with an
// N-cycle latency. Operand pairs arrive on a valid/ready stream and are
// registered onto the divider's data_rdy/dividend/divisor inputs. Issue is
// metered by a credit counter that mirrors free slots in the downstream result
// buffer. A zero divisor is replaced with 1 so the divider never sees x/0, and
// a dz flag travels alongside the operation so it appears together with the
// divider's rdy. A flush request drains everything in flight and reports
// completion with a one-cycle pulse.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   upstream operand pair valid
//   in_ready     out  block can accept an operand pair this cycle
//   in_dividend  in   [N-1:0] dividend
//   in_divisor   in   [M-1:0] divisor
//   data_rdy     out  to divider: operands valid this cycle
//   dividend     out  [N-1:0] to divider (holds when data_rdy=0)
//   divisor      out  [M-1:0] to divider (holds when data_rdy=0)
//   credit_ret   in   one-cycle pulse: downstream buffer freed one entry
//   dz_flag      out  asserted with divider rdy for a divide-by-zero result
//   flush        in   drain request (level), honoured only in RUN
//   flush_done   out  one-cycle pulse when the drain has completed
//   credit_err   out  sticky: a credit came back while the count was full
//   credits      out  [CW-1:0] current credit count
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int N       = 5,
  parameter int M       = 3,
  parameter int CREDITS = 8,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_dividend,
  input  logic [M-1:0]  in_divisor,
  output logic          data_rdy,
  output logic [N-1:0]  dividend,
  output logic [M-1:0]  divisor,
  input  logic          credit_ret,
  output logic          dz_flag,
  input  logic          flush,
  output logic          flush_done,
  output logic          credit_err,
  output logic [CW-1:0] credits
);

  // FSM encoding kept as plain constants for compatibility with older flows.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CW-1:0] CREDITS_FULL = CW'(CREDITS);
  localparam logic [CW-1:0] CREDIT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CREDIT_ZERO  = {CW{1'b0}};
  localparam logic [M-1:0]  DIVISOR_ONE  = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-1:0]  DIVISOR_ZERO = {M{1'b0}};
  localparam logic [N-1:0]  DIVIDEND_ZERO = {N{1'b0}};
  localparam logic [N-1:0]  PIPE_EMPTY   = {N{1'b0}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q,      state_d;
  logic [CW-1:0] credits_q,    credits_d;
  logic          credit_err_q, credit_err_d;
  logic          data_rdy_q,   data_rdy_d;
  logic          dz_q,         dz_d;
  logic [N-1:0]  dividend_q,   dividend_d;
  logic [M-1:0]  divisor_q,    divisor_d;
  logic [N-1:0]  vld_sr_q,     vld_sr_d;
  logic [N-1:0]  dz_sr_q,      dz_sr_d;
  logic          flush_done_q, flush_done_d;

  logic          accept;
  logic          divisor_is_zero;
  logic          pipe_empty;

  // in_ready depends only on registered state plus the flush/rst controls, so
  // there is no combinational path from in_valid back to in_ready.
  assign in_ready = ~rst
                  & (state_q == ST_RUN)
                  & ~flush
                  & (credits_q != CREDIT_ZERO);

  assign accept          = in_valid & in_ready;
  assign divisor_is_zero = (in_divisor == DIVISOR_ZERO);

  // Nothing left anywhere between this block and the divider's rdy output.
  assign pipe_empty = (vld_sr_q == PIPE_EMPTY) & ~data_rdy_q;

  // FSM next-state: RUN -> DRAIN on flush, DRAIN -> DONE once empty, DONE -> RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // The done pulse is registered alongside the DONE state so it lasts one cycle.
  always_comb begin
    if (state_d == ST_DONE) begin
      flush_done_d = 1'b1;
    end else begin
      flush_done_d = 1'b0;
    end
  end

  // Credit counter: accept consumes, credit_ret refunds; both together cancel.
  // A refund at a full count is dropped and latched as an error.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (accept && credit_ret) begin
      credits_d = credits_q;
    end else if (accept) begin
      credits_d = credits_q - CREDIT_ONE;
    end else if (credit_ret) begin
      if (credits_q == CREDITS_FULL) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CREDIT_ONE;
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // Operand register: substitute divisor 1 for a zero divisor and tag it dz.
  always_comb begin
    data_rdy_d = accept;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    dz_d       = 1'b0;
    if (accept) begin
      dividend_d = in_dividend;
      if (divisor_is_zero) begin
        divisor_d = DIVISOR_ONE;
        dz_d      = 1'b1;
      end else begin
        divisor_d = in_divisor;
        dz_d      = 1'b0;
      end
    end else begin
      dz_d = 1'b0;
    end
  end

  // In-flight trackers shift every cycle so their last stage lines up with the
  // divider's rdy, N cycles after data_rdy is sampled.
  always_comb begin
    vld_sr_d = {vld_sr_q[N-2:0], data_rdy_q};
    dz_sr_d  = {dz_sr_q[N-2:0],  dz_q};
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      credits_q    <= CREDITS_FULL;
      credit_err_q <= 1'b0;
      data_rdy_q   <= 1'b0;
      dz_q         <= 1'b0;
      dividend_q   <= DIVIDEND_ZERO;
      divisor_q    <= DIVISOR_ONE;
      vld_sr_q     <= PIPE_EMPTY;
      dz_sr_q      <= PIPE_EMPTY;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      data_rdy_q   <= data_rdy_d;
      dz_q         <= dz_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      vld_sr_q     <= vld_sr_d;
      dz_sr_q      <= dz_sr_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign data_rdy   = data_rdy_q;
  assign dividend   = dividend_q;
  assign divisor    = divisor_q;
  // Qualify with the valid stage so a stale dz bit can never leak out.
  assign dz_flag    = vld_sr_q[N-1] & dz_sr_q[N-1];
  assign flush_done = flush_done_q;
  assign credit_err = credit_err_q;
  assign credits    = credits_q;

endmodule
